sumatoria_ctrl: RTL and testbench

- Sequencer for the 16-lane sign-magnitude summation datapath.
- Fetches NUM_BLOCKS consecutive 16-word blocks from a synchronous-read data memory and presents each block to the datapath as its packed 16×32 operand bus.
- Accumulates the per-block sign-magnitude results into a running total and reports one saturated sign-magnitude result with a start/done handshake.
- Sits between the control register interface and the summation datapath / data memory.

---
 rtl/sumatoria_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_sumatoria_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumatoria_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sumatoria_ctrl
// Description : Sequencer for the 16-lane sign-magnitude summation datapath.
//               Streams NUM_BLOCKS consecutive 16-word blocks from a
//               synchronous-read memory onto a packed operand bus, folds each
//               block's sign-magnitude sum into a running total and reports a
//               saturated sign-magnitude result with a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sumatoria_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [7:0]            num_blocks,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [LANES*32-1:0]   rd_bus,
    input  logic [31:0]           sum_in,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           result,
    output logic                  overflow
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_LANE = 4'(LANES - 1);
    localparam logic [24:0] MAG_MAX  = 25'd32767;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [3:0]             k_q,       k_d;
    logic [7:0]             b_q,       b_d;
    logic [7:0]             nb_q,      nb_d;
    logic [ADDR_W-1:0]      base_q,    base_d;
    logic signed [24:0]     acc_q,     acc_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic                   rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0]      addr_q,    addr_d;
    logic [LANES*32-1:0]    rd_bus_q,  rd_bus_d;
    logic [31:0]            result_q,  result_d;
    logic                   ovf_q,     ovf_d;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    logic signed [24:0]     addend;
    logic [3:0]             fill_lane;
    logic [7:0]             b_inc;
    logic                   unused_sum_hi;

    // The datapath only defines the low half-word; the upper bits are ignored.
    assign unused_sum_hi = ^sum_in[31:16];

    // Word address of lane k in block b, wrapping at the memory size.
    function automatic logic [ADDR_W-1:0] blk_addr(
        input logic [ADDR_W-1:0] base,
        input logic [7:0]        b,
        input logic [3:0]        k
    );
        blk_addr = base + ADDR_W'({b, 4'b0000}) + ADDR_W'(k);
    endfunction

    // Accumulator to {overflow, sign-magnitude result}; zero is always +0.
    function automatic logic [32:0] to_sign_mag(input logic signed [24:0] a);
        logic [24:0] mag;
        logic [14:0] mag15;
        logic        sat;
        mag   = a[24] ? 25'(-a) : 25'(a);
        sat   = (mag > MAG_MAX);
        mag15 = sat ? 15'h7FFF : mag[14:0];
        to_sign_mag = {sat, 16'h0000, a[24], mag15};
    endfunction

    // Sign-magnitude datapath result as a signed addend; -0 naturally yields 0.
    always_comb begin
        addend = sum_in[15] ? -$signed({10'b0, sum_in[14:0]})
                            :  $signed({10'b0, sum_in[14:0]});
    end

    // Lane that the data currently on mem_rdata belongs to (previous k).
    assign fill_lane = k_q - 4'd1;
    assign b_inc     = b_q + 8'd1;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        b_d      = b_q;
        nb_d     = nb_q;
        base_d   = base_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_en_d  = rd_en_q;
        addr_d   = addr_q;
        rd_bus_d = rd_bus_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    nb_d     = num_blocks;
                    acc_d    = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    b_d      = '0;
                    k_d      = '0;
                    if (num_blocks == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        busy_d  = 1'b1;
                        rd_en_d = 1'b1;
                        addr_d  = base_addr;
                    end
                end
            end

            ST_FETCH: begin
                // Word requested at k-1 arrives now.
                if (k_q != 4'd0) begin
                    rd_bus_d[{fill_lane, 5'b00000} +: 32] = mem_rdata;
                end
                if (k_q == LAST_LANE) begin
                    state_d = ST_WAIT;
                    rd_en_d = 1'b0;
                end else begin
                    k_d    = k_q + 4'd1;
                    addr_d = blk_addr(base_q, b_q, k_q + 4'd1);
                end
            end

            ST_WAIT: begin
                // Last lane's data lands one cycle after the final request.
                rd_bus_d[{LAST_LANE, 5'b00000} +: 32] = mem_rdata;
                state_d = ST_ACCUM;
            end

            ST_ACCUM: begin
                acc_d = acc_q + addend;
                b_d   = b_inc;
                if (b_inc == nb_q) begin
                    state_d                      = ST_DONE;
                    busy_d                       = 1'b0;
                    done_d                       = 1'b1;
                    {ovf_d, result_d}            = to_sign_mag(acc_q + addend);
                end else begin
                    state_d = ST_FETCH;
                    k_d     = '0;
                    rd_en_d = 1'b1;
                    addr_d  = blk_addr(base_q, b_inc, 4'd0);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any run and clears every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            b_q      <= '0;
            nb_q     <= '0;
            base_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            rd_bus_q <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            b_q      <= b_d;
            nb_q     <= nb_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            rd_bus_q <= rd_bus_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign rd_bus    = rd_bus_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sumatoria_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sumatoria_ctrl
// Description : Self-checking bench for sumatoria_ctrl with a synchronous
//               memory model, a behavioural datapath and result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sumatoria_ctrl;

    localparam int ADDR_W = 10;
    localparam int LANES  = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [7:0]           num_blocks;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [31:0]          mem_rdata;
    logic [LANES*32-1:0]  rd_bus;
    logic [31:0]          sum_in;
    logic                 busy;
    logic                 done;
    logic [31:0]          result;
    logic                 overflow;

    sumatoria_ctrl #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_blocks (num_blocks),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rd_bus     (rd_bus),
        .sum_in     (sum_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory and datapath models ----------------
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    initial mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    logic        dp_force;
    logic [31:0] dp_force_val;

    function automatic logic [31:0] dp_model(input logic [LANES*32-1:0] bus);
        int          t;
        logic [31:0] w;
        t = 0;
        for (int i = 0; i < LANES; i++) begin
            w = bus[32*i +: 32];
            if (w[15]) t = t - int'(w[14:0]);
            else       t = t + int'(w[14:0]);
        end
        if (t < 0) dp_model = {16'h0, 1'b1, 15'(-t)};
        else       dp_model = {16'h0, 1'b0, 15'(t)};
    endfunction

    assign sum_in = dp_force ? dp_force_val : dp_model(rd_bus);

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t               exp_q[$];
    logic [ADDR_W-1:0]  addr_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
    endtask

    // Every memory read must match the next expected address.
    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            if (addr_q.size() == 0) begin
                n_total++;
                $display("FAIL mem_read: unexpected read at addr 0x%03h", mem_addr);
            end else begin
                chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
        end
    end

    // Scoreboard: each done pulse retires one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL done: spurious done pulse, result 0x%08h", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result",   result,               e.res);
                chk("overflow", {31'b0, overflow},    {31'b0, e.ovf});
                chk("latency",  32'(cyc - t_start + 1), 32'(e.lat));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill(input int pat, input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            a = base + ADDR_W'(i);
            case (pat)
                0: if (i < 16) mem[a] = 32'h0000_0001;
                1: if (i < 16) mem[a] = (i < 8) ? 32'h0000_0064 : 32'h0000_801E;
                2: if (i == 0) mem[a] = 32'h0000_0005;
                   else if (i == 16) mem[a] = 32'h0000_800C;
                3: if (i < 16) mem[a] = (i < 8) ? 32'h0000_0009 : 32'h0000_8009;
                4: if (i == 0 || i == 16) mem[a] = 32'h0000_7000;
                default: ;
            endcase
        end
    endtask

    task automatic push_addrs(input logic [ADDR_W-1:0] base, input int nb, input int nk_last);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 16; k++) begin
                if (b < nb - 1 || k < nk_last)
                    addr_q.push_back(base + ADDR_W'(16 * b + k));
            end
        end
    endtask

    task automatic run(input logic [ADDR_W-1:0] base, input logic [7:0] nb,
                       input int glitch_at, input logic [31:0] er, input logic eo);
        exp_t e;
        bit   seen;
        e.res = er;
        e.ovf = eo;
        e.lat = 1 + 18 * int'(nb);
        exp_q.push_back(e);
        push_addrs(base, int'(nb), 16);
        @(negedge clk);
        base_addr  = base;
        num_blocks = nb;
        start      = 1'b1;
        t_start    = cyc + 1;
        seen       = 1'b0;
        for (int i = 1; i <= 18 * int'(nb) + 20 && !seen; i++) begin
            @(negedge clk);
            start = (i == glitch_at);
            if (i == glitch_at) num_blocks = 8'd0;
            if (i == 1 && nb != 8'd0) chk("busy_running", {31'b0, busy}, 32'd1);
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            n_total++;
            $display("FAIL done_timeout: got no done, expected done after %0d cycles", e.lat);
            exp_q.delete();
            addr_q.delete();
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("busy_idle",  {31'b0, busy}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [7:0]        nb;
        int                pat;
        logic              force_en;
        logic [31:0]       force_val;
        logic [31:0]       exp_res;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{10'd100,  8'd1, 0, 1'b0, 32'h0,         32'h0000_0010, 1'b0};
        vecs[1] = '{10'd200,  8'd1, 1, 1'b0, 32'h0,         32'h0000_0230, 1'b0};
        vecs[2] = '{10'd300,  8'd2, 2, 1'b0, 32'h0,         32'h0000_8007, 1'b0};
        vecs[3] = '{10'd400,  8'd1, 3, 1'b1, 32'h0000_8000, 32'h0000_0000, 1'b0};
        vecs[4] = '{10'd1016, 8'd2, 4, 1'b0, 32'h0,         32'h0000_7FFF, 1'b1};
        vecs[5] = '{10'd500,  8'd0, 0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};

        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        num_blocks   = '0;
        dp_force     = 1'b0;
        dp_force_val = 32'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",     {31'b0, busy},      32'd0);
        chk("rst_done",     {31'b0, done},      32'd0);
        chk("rst_rd_en",    {31'b0, mem_rd_en}, 32'd0);
        chk("rst_overflow", {31'b0, overflow},  32'd0);
        chk("rst_result",   result,             32'd0);
        chk("rst_mem_addr", 32'(mem_addr),      32'd0);
        chk("rst_rd_bus",   {31'b0, |rd_bus},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].pat, vecs[v].base);
            dp_force     = vecs[v].force_en;
            dp_force_val = vecs[v].force_val;
            run(vecs[v].base, vecs[v].nb, -1, vecs[v].exp_res, vecs[v].exp_ovf);
        end
        dp_force = 1'b0;

        // start pulsed mid-FETCH (with num_blocks = 0) must be ignored
        fill(0, 10'd100);
        run(10'd100, 8'd1, 5, 32'h0000_0010, 1'b0);

        // Reset mid-run at FETCH k = 7
        fill(0, 10'd600);
        push_addrs(10'd600, 1, 8);
        @(negedge clk);
        base_addr  = 10'd600;
        num_blocks = 8'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_k7_addr", 32'(mem_addr), 32'd607);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",     {31'b0, busy},      32'd0);
        chk("abort_rd_en",    {31'b0, mem_rd_en}, 32'd0);
        chk("abort_result",   result,             32'd0);
        chk("abort_overflow", {31'b0, overflow},  32'd0);
        chk("abort_rd_bus",   {31'b0, |rd_bus},   32'd0);
        addr_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_hold_rd_en", {31'b0, mem_rd_en}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", {31'b0, done}, 32'd0);

        // Normal run after reset release
        fill(vecs[1].pat, vecs[1].base);
        run(vecs[1].base, vecs[1].nb, -1, vecs[1].exp_res, vecs[1].exp_ovf);

        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            n_total++;
            $display("FAIL leftovers: got %0d results and %0d reads outstanding, expected 0",
                     exp_q.size(), addr_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
